// File: rtl/fpu_vector_checker.sv
// Vector-table stimulus engine for an FPU: issues stored operations over valid/ready,
// retires results by tag (any order), and reports pass/fail counts, first failure and timeout.
module fpu_vector_checker #(
    parameter int unsigned Width         = 64,
    parameter int unsigned Depth         = 16,
    parameter int unsigned CtrlWidth     = 16,
    parameter int unsigned MaxInflight   = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned AW           = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_valid_i,
    input  logic [AW-1:0]          load_addr_i,
    input  logic [CtrlWidth-1:0]   load_ctrl_i,
    input  logic [3*Width-1:0]     load_ops_i,
    input  logic [Width-1:0]       load_exp_i,
    input  logic [Width-1:0]       load_mask_i,
    input  logic                   start_i,
    input  logic [AW:0]            num_vec_i,
    output logic [3*Width-1:0]     fpu_operands_o,
    output logic [CtrlWidth-1:0]   fpu_ctrl_o,
    output logic [AW-1:0]          fpu_tag_o,
    output logic                   fpu_in_valid_o,
    input  logic                   fpu_in_ready_i,
    input  logic [Width-1:0]       fpu_result_i,
    input  logic [AW-1:0]          fpu_tag_i,
    input  logic                   fpu_out_valid_i,
    output logic                   fpu_out_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [AW:0]            pass_cnt_o,
    output logic [AW:0]            fail_cnt_o,
    output logic                   first_fail_valid_o,
    output logic [AW-1:0]          first_fail_idx_o,
    output logic                   timeout_o
);

    localparam int unsigned IW = $clog2(MaxInflight + 1);
    localparam int unsigned WW = $clog2(TimeoutCycles + 1);
    localparam logic [IW-1:0] MaxInfl     = IW'(MaxInflight);
    localparam logic [IW-1:0] InflOne     = IW'(1);
    localparam logic [WW-1:0] TimeoutLast = WW'(TimeoutCycles - 1);
    localparam logic [WW-1:0] WdOne       = WW'(1);
    localparam logic [AW:0]   CntOne      = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    logic [CtrlWidth-1:0] ctrl_mem [Depth];
    logic [3*Width-1:0]   ops_mem  [Depth];
    logic [Width-1:0]     exp_mem  [Depth];
    logic [Width-1:0]     mask_mem [Depth];

    state_e         state_q;
    logic [AW:0]    num_vec_q;
    logic [AW:0]    issue_idx_q;
    logic [IW-1:0]  inflight_q, inflight_d;
    logic [WW-1:0]  wd_q;
    logic           busy_q, done_q, timeout_q, first_fail_valid_q;
    logic [AW:0]    pass_cnt_q, fail_cnt_q;
    logic [AW-1:0]  first_fail_idx_q;

    logic           in_valid_s, out_ready_s, issue_hs_s, retire_hs_s, retire_dec_s;
    logic           tag_ok_s, pass_s;
    logic [AW-1:0]  issue_slot_s;

    // Slot table write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == IDLE) && load_valid_i) begin
            ctrl_mem[load_addr_i] <= load_ctrl_i;
            ops_mem[load_addr_i]  <= load_ops_i;
            exp_mem[load_addr_i]  <= load_exp_i;
            mask_mem[load_addr_i] <= load_mask_i;
        end
    end

    // Once the watchdog fires, both handshakes are closed so late results are abandoned.
    assign issue_slot_s = issue_idx_q[AW-1:0];
    assign in_valid_s   = (state_q == ISSUE) && (inflight_q < MaxInfl) && !timeout_q;
    assign out_ready_s  = ((state_q == ISSUE) || (state_q == DRAIN)) && !timeout_q;
    assign issue_hs_s   = in_valid_s && fpu_in_ready_i;
    assign retire_hs_s  = out_ready_s && fpu_out_valid_i;
    assign retire_dec_s = retire_hs_s && (inflight_q != {IW{1'b0}});
    assign tag_ok_s     = ({1'b0, fpu_tag_i} < num_vec_q);
    assign pass_s       = tag_ok_s &&
                          (((fpu_result_i ^ exp_mem[fpu_tag_i]) & mask_mem[fpu_tag_i]) == {Width{1'b0}});

    // Outstanding-operation count; simultaneous issue and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (issue_hs_s && !retire_dec_s) begin
            inflight_d = inflight_q + InflOne;
        end else if (!issue_hs_s && retire_dec_s) begin
            inflight_d = inflight_q - InflOne;
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Run-control FSM with counters, watchdog and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            num_vec_q          <= {(AW+1){1'b0}};
            issue_idx_q        <= {(AW+1){1'b0}};
            inflight_q         <= {IW{1'b0}};
            wd_q               <= {WW{1'b0}};
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            timeout_q          <= 1'b0;
            pass_cnt_q         <= {(AW+1){1'b0}};
            fail_cnt_q         <= {(AW+1){1'b0}};
            first_fail_valid_q <= 1'b0;
            first_fail_idx_q   <= {AW{1'b0}};
        end else begin
            inflight_q <= inflight_d;
            if (issue_hs_s) begin
                issue_idx_q <= issue_idx_q + CntOne;
            end
            if (retire_hs_s) begin
                if (pass_s) begin
                    pass_cnt_q <= pass_cnt_q + CntOne;
                end else begin
                    fail_cnt_q <= fail_cnt_q + CntOne;
                    if (!first_fail_valid_q) begin
                        first_fail_valid_q <= 1'b1;
                        first_fail_idx_q   <= fpu_tag_i;
                    end
                end
            end
            if (issue_hs_s || retire_hs_s) begin
                wd_q <= {WW{1'b0}};
            end else if (busy_q && (inflight_q != {IW{1'b0}}) && !timeout_q) begin
                if (wd_q == TimeoutLast) begin
                    timeout_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + WdOne;
                end
            end

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        num_vec_q          <= num_vec_i;
                        issue_idx_q        <= {(AW+1){1'b0}};
                        inflight_q         <= {IW{1'b0}};
                        wd_q               <= {WW{1'b0}};
                        timeout_q          <= 1'b0;
                        pass_cnt_q         <= {(AW+1){1'b0}};
                        fail_cnt_q         <= {(AW+1){1'b0}};
                        first_fail_valid_q <= 1'b0;
                        if (num_vec_i != {(AW+1){1'b0}}) begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (timeout_q) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        inflight_q <= {IW{1'b0}};
                    end else if (issue_hs_s && ((issue_idx_q + CntOne) == num_vec_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (timeout_q || (inflight_d == {IW{1'b0}})) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        inflight_q <= {IW{1'b0}};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_operands_o     = (state_q == ISSUE) ? ops_mem[issue_slot_s]  : {(3*Width){1'b0}};
    assign fpu_ctrl_o         = (state_q == ISSUE) ? ctrl_mem[issue_slot_s] : {CtrlWidth{1'b0}};
    assign fpu_tag_o          = issue_slot_s;
    assign fpu_in_valid_o     = in_valid_s;
    assign fpu_out_ready_o    = out_ready_s;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pass_cnt_o         = pass_cnt_q;
    assign fail_cnt_o         = fail_cnt_q;
    assign first_fail_valid_o = first_fail_valid_q;
    assign first_fail_idx_o   = first_fail_idx_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Directed bench for fpu_vector_checker: issue scoreboard plus a behavioural FPU driven step by step.
module tb_fpu_vector_checker;

    localparam int W  = 64;
    localparam int D  = 16;
    localparam int CW = 16;
    localparam int MI = 4;
    localparam int TO = 24;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            load_valid_i;
    logic [AW-1:0]   load_addr_i;
    logic [CW-1:0]   load_ctrl_i;
    logic [3*W-1:0]  load_ops_i;
    logic [W-1:0]    load_exp_i;
    logic [W-1:0]    load_mask_i;
    logic            start_i;
    logic [AW:0]     num_vec_i;
    logic [3*W-1:0]  fpu_operands_o;
    logic [CW-1:0]   fpu_ctrl_o;
    logic [AW-1:0]   fpu_tag_o;
    logic            fpu_in_valid_o;
    logic            fpu_in_ready_i;
    logic [W-1:0]    fpu_result_i;
    logic [AW-1:0]   fpu_tag_i;
    logic            fpu_out_valid_i;
    logic            fpu_out_ready_o;
    logic            busy_o;
    logic            done_o;
    logic [AW:0]     pass_cnt_o;
    logic [AW:0]     fail_cnt_o;
    logic            first_fail_valid_o;
    logic [AW-1:0]   first_fail_idx_o;
    logic            timeout_o;

    fpu_vector_checker #(
        .Width(W), .Depth(D), .CtrlWidth(CW), .MaxInflight(MI), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .load_valid_i(load_valid_i), .load_addr_i(load_addr_i), .load_ctrl_i(load_ctrl_i),
        .load_ops_i(load_ops_i), .load_exp_i(load_exp_i), .load_mask_i(load_mask_i),
        .start_i(start_i), .num_vec_i(num_vec_i),
        .fpu_operands_o(fpu_operands_o), .fpu_ctrl_o(fpu_ctrl_o), .fpu_tag_o(fpu_tag_o),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_result_i(fpu_result_i), .fpu_tag_i(fpu_tag_i), .fpu_out_valid_i(fpu_out_valid_i),
        .fpu_out_ready_o(fpu_out_ready_o), .busy_o(busy_o), .done_o(done_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
        .first_fail_valid_o(first_fail_valid_o), .first_fail_idx_o(first_fail_idx_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]  tag;
        logic [3*W-1:0] ops;
        logic [CW-1:0]  ctrl;
    } iss_t;

    iss_t           sb_q[$];
    iss_t           mon_e;
    logic [3*W-1:0] t_ops   [D];
    logic [CW-1:0]  t_ctrl  [D];
    logic [W-1:0]   t_exp   [D];
    logic [W-1:0]   t_mask  [D];
    logic [W-1:0]   t_truth [D];
    int tests = 0, failed = 0, issued = 0;
    int exp_pass, exp_fail, exp_ffi, cur_n, base;
    bit exp_ffv;

    task automatic chk(input string name, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue monitor: each request handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        if (fpu_in_valid_o && fpu_in_ready_i) begin
            issued++;
            chk("issue_expected", 192'(sb_q.size() != 0), 192'(1'b1));
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("issue_tag", 192'(fpu_tag_o), 192'(mon_e.tag));
                chk("issue_ops", fpu_operands_o, mon_e.ops);
                chk("issue_ctrl", 192'(fpu_ctrl_o), 192'(mon_e.ctrl));
            end
        end
    end

    task automatic load(input int a, input logic [CW-1:0] c, input logic [W-1:0] o0,
                        input logic [W-1:0] o1, input logic [W-1:0] o2, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] tr);
        t_ops[a] = {o2, o1, o0};
        t_ctrl[a] = c; t_exp[a] = e; t_mask[a] = m; t_truth[a] = tr;
        load_valid_i = 1'b1; load_addr_i = a[AW-1:0]; load_ctrl_i = c;
        load_ops_i = {o2, o1, o0}; load_exp_i = e; load_mask_i = m;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic start(input int n);
        cur_n = n; exp_pass = 0; exp_fail = 0; exp_ffv = 1'b0; exp_ffi = 0;
        for (int i = 0; i < n; i++) sb_q.push_back({i[AW-1:0], t_ops[i], t_ctrl[i]});
        base = issued;
        num_vec_i = n[AW:0]; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_issued(input int target);
        for (int b = 0; b < 200 && issued < target; b++) tick();
        chk("issue_count", 192'(issued), 192'(target));
    endtask

    // Behavioural FPU returns the true result for a tag; the model scores it.
    task automatic retire(input int tag);
        fpu_out_valid_i = 1'b1; fpu_tag_i = tag[AW-1:0]; fpu_result_i = t_truth[tag];
        chk("retire_ready", 192'(fpu_out_ready_o), 192'(1'b1));
        if (tag < cur_n && ((t_truth[tag] ^ t_exp[tag]) & t_mask[tag]) == 64'd0) begin
            exp_pass++;
        end else begin
            exp_fail++;
            if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffi = tag; end
        end
        tick();
        fpu_out_valid_i = 1'b0;
    endtask

    task automatic check_counts();
        chk("pass_cnt", 192'(pass_cnt_o), 192'(exp_pass));
        chk("fail_cnt", 192'(fail_cnt_o), 192'(exp_fail));
        chk("ff_valid", 192'(first_fail_valid_o), 192'(exp_ffv));
        if (exp_ffv) chk("ff_idx", 192'(first_fail_idx_o), 192'(exp_ffi));
    endtask

    task automatic run_pair();
        fpu_in_ready_i = 1'b1;
        start(2);
        chk("busy_after_start", 192'(busy_o), 192'(1'b1));
        chk("valid_after_start", 192'(fpu_in_valid_o), 192'(1'b1));
        wait_issued(base + 2);
        fpu_in_ready_i = 1'b0;
        retire(0);
        retire(1);
        chk("done_pulse", 192'(done_o), 192'(1'b1));
        chk("busy_at_done", 192'(busy_o), 192'(1'b0));
        check_counts();
        tick();
        chk("done_clear", 192'(done_o), 192'(1'b0));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 192'(busy_o), 192'(1'b0));
        chk({tag, "_done"}, 192'(done_o), 192'(1'b0));
        chk({tag, "_in_valid"}, 192'(fpu_in_valid_o), 192'(1'b0));
        chk({tag, "_out_ready"}, 192'(fpu_out_ready_o), 192'(1'b0));
        chk({tag, "_pass"}, 192'(pass_cnt_o), 192'(0));
        chk({tag, "_fail"}, 192'(fail_cnt_o), 192'(0));
        chk({tag, "_ffv"}, 192'(first_fail_valid_o), 192'(1'b0));
        chk({tag, "_ffi"}, 192'(first_fail_idx_o), 192'(0));
        chk({tag, "_timeout"}, 192'(timeout_o), 192'(1'b0));
        chk({tag, "_ops"}, fpu_operands_o, 192'(0));
        chk({tag, "_ctrl"}, 192'(fpu_ctrl_o), 192'(0));
        chk({tag, "_tag"}, 192'(fpu_tag_o), 192'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_ni = 1'b0; load_valid_i = 1'b0; load_addr_i = '0; load_ctrl_i = '0;
        load_ops_i = '0; load_exp_i = '0; load_mask_i = '0; start_i = 1'b0; num_vec_i = '0;
        fpu_in_ready_i = 1'b0; fpu_result_i = '0; fpu_tag_i = '0; fpu_out_valid_i = 1'b0;
        cur_n = 0; exp_pass = 0; exp_fail = 0; exp_ffv = 1'b0; exp_ffi = 0; base = 0;
        tick(); tick();
        check_idle_zero("reset");
        rst_ni = 1'b1;
        tick();

        // FP32 1.0+1.0 and 2.0+3.0, all matching
        load(0, 16'h0001, 64'h3f800000, 64'h3f800000, 64'h0, 64'h40000000, 64'hFFFFFFFF, 64'h40000000);
        load(1, 16'h0001, 64'h40000000, 64'h40400000, 64'h0, 64'h40A00000, 64'hFFFFFFFF, 64'h40A00000);
        run_pair();
        chk("fp_pass2", 192'(pass_cnt_o), 192'(2));

        // Wrong expectation in slot 1, then masked-off LSB
        load(1, 16'h0001, 64'h40000000, 64'h40400000, 64'h0, 64'h40A00001, 64'hFFFFFFFF, 64'h40A00000);
        run_pair();
        chk("fp_fail_idx", 192'(first_fail_idx_o), 192'(1));
        load(1, 16'h0001, 64'h40000000, 64'h40400000, 64'h0, 64'h40A00001, 64'hFFFFFFFE, 64'h40A00000);
        run_pair();

        // Inflight limit and out-of-order retirement
        for (int i = 0; i < 6; i++)
            load(i, 16'(256 + i), 64'(i + 1), 64'(i + 2), 64'(i + 3), 64'(4096 + i),
                 64'hFFFF_FFFF_FFFF_FFFF, 64'(4096 + i));
        fpu_in_ready_i = 1'b1;
        start(6);
        repeat (20) tick();
        chk("limit_issued", 192'(issued - base), 192'(MI));
        chk("limit_valid_low", 192'(fpu_in_valid_o), 192'(1'b0));
        retire(3);
        chk("limit_valid_reopen", 192'(fpu_in_valid_o), 192'(1'b1));
        tick();
        chk("limit_one_more", 192'(issued - base), 192'(MI + 1));
        chk("limit_valid_again", 192'(fpu_in_valid_o), 192'(1'b0));
        retire(1);
        tick();
        chk("limit_all_issued", 192'(issued - base), 192'(6));
        retire(0); retire(2); retire(4); retire(5);
        chk("ooo_done", 192'(done_o), 192'(1'b1));
        check_counts();
        tick();

        // Returned tag beyond num_vec counts as a failure
        load(7, 16'h0007, 64'h7, 64'h7, 64'h7, 64'h77, 64'h0, 64'h77);
        fpu_in_ready_i = 1'b1;
        start(1);
        wait_issued(base + 1);
        fpu_in_ready_i = 1'b0;
        retire(7);
        chk("badtag_done", 192'(done_o), 192'(1'b1));
        check_counts();
        tick();

        // Watchdog with a silent FPU
        fpu_in_ready_i = 1'b1;
        start(2);
        wait_issued(base + 2);
        fpu_in_ready_i = 1'b0;
        repeat (TO - 1) tick();
        chk("wd_not_yet", 192'(timeout_o), 192'(1'b0));
        tick();
        chk("wd_fired", 192'(timeout_o), 192'(1'b1));
        chk("wd_done_later", 192'(done_o), 192'(1'b0));
        tick();
        chk("wd_done", 192'(done_o), 192'(1'b1));
        chk("wd_ready_low", 192'(fpu_out_ready_o), 192'(1'b0));
        chk("wd_busy_low", 192'(busy_o), 192'(1'b0));
        check_counts();
        tick();
        chk("wd_done_clear", 192'(done_o), 192'(1'b0));
        chk("wd_sticky", 192'(timeout_o), 192'(1'b1));
        chk("wd_ready_idle", 192'(fpu_out_ready_o), 192'(1'b0));

        // Empty run
        fpu_in_ready_i = 1'b1;
        start(0);
        chk("empty_done", 192'(done_o), 192'(1'b1));
        chk("empty_no_valid", 192'(fpu_in_valid_o), 192'(1'b0));
        chk("empty_timeout_clr", 192'(timeout_o), 192'(1'b0));
        tick();
        chk("empty_done_clear", 192'(done_o), 192'(1'b0));
        chk("empty_no_issue", 192'(issued), 192'(base));

        // Start while draining is ignored
        start(2);
        wait_issued(base + 2);
        fpu_in_ready_i = 1'b0;
        num_vec_i = 5'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_busy", 192'(busy_o), 192'(1'b1));
        retire(0);
        retire(1);
        chk("restart_done", 192'(done_o), 192'(1'b1));
        check_counts();
        tick();
        chk("restart_no_issue", 192'(issued), 192'(base + 2));

        // Reset while draining, then a late result must be refused
        fpu_in_ready_i = 1'b1;
        start(2);
        wait_issued(base + 2);
        fpu_in_ready_i = 1'b0;
        retire(0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check_idle_zero("drain_reset");
        fpu_out_valid_i = 1'b1; fpu_tag_i = 4'd1; fpu_result_i = t_truth[1];
        tick();
        fpu_out_valid_i = 1'b0;
        chk("late_result_pass", 192'(pass_cnt_o), 192'(0));
        chk("late_result_fail", 192'(fail_cnt_o), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
